sym_generator: RTL and testbench

- Responder to the game-period controller's generator handshake.
- On a startGen pulse it emits pseudo-random 4-bit symbols, one per Clk1Hz tick, until symGenMax symbols have been issued or stopGen arrives.
- It reports per-symbol strobes, a running symbol count, a special-symbol count and a completion pulse back to the controller and the display path.
- It sits between the game-period controller and the symbol display/answer logic.

---
 rtl/sym_generator_pkg.sv | 17 +
 rtl/sym_lfsr.sv | 38 +++
 rtl/sym_generator.sv | 125 ++++++++++++
 tb/tb_sym_generator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_generator_pkg.sv
// Shared types and defaults for the symbol generator.
// Holds the FSM state type, LFSR defaults and the symbol width.
package sym_generator_pkg;

    localparam int SYM_W = 4;

    localparam logic [15:0] DEF_SEED = 16'hACE1;
    localparam logic [15:0] DEF_TAPS = 16'hB400;
    localparam logic [SYM_W-1:0] DEF_SPECIAL = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } genState_t;

endpackage

// File: rtl/sym_lfsr.sv
// 16-bit Galois LFSR (right-shift form) with a step enable.
// Ports: Clk100M, Rst_n, stepEn in; symNext = low nibble of the next state.
module sym_lfsr
    import sym_generator_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED,
    parameter logic [15:0] TAPS = DEF_TAPS
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             stepEn,
    output logic [SYM_W-1:0] symNext
);

    // An all-zero state would lock the register, so fall back to 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr;
    logic [15:0] lfsrNext;

    always_comb begin
        lfsrNext = lfsr >> 1;
        if (lfsr[0]) begin
            lfsrNext = (lfsr >> 1) ^ TAPS;
        end
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            lfsr <= SEED_EFF;
        end else if (stepEn) begin
            lfsr <= lfsrNext;
        end
    end

    assign symNext = lfsrNext[SYM_W-1:0];

endmodule

// File: rtl/sym_generator.sv
// Symbol generator: emits one pseudo-random symbol per Clk1Hz tick.
// Ports: Clk100M, Rst_n, Clk1Hz, startGen, stopGen, symGenMax in;
// symValid, symCode, isSpecial, symCount, specialCount, busy, genDone out.
module sym_generator
    import sym_generator_pkg::*;
#(
    parameter logic [15:0]      SEED         = DEF_SEED,
    parameter logic [15:0]      TAPS         = DEF_TAPS,
    parameter logic [SYM_W-1:0] SPECIAL_CODE = DEF_SPECIAL,
    parameter int               CNT_W        = 32
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             Clk1Hz,
    input  logic             startGen,
    input  logic             stopGen,
    input  logic [CNT_W-1:0] symGenMax,
    output logic             symValid,
    output logic [SYM_W-1:0] symCode,
    output logic             isSpecial,
    output logic [CNT_W-1:0] symCount,
    output logic [7:0]       specialCount,
    output logic             busy,
    output logic             genDone
);

    genState_t state;
    genState_t stateNext;

    logic             loadRun;
    logic             stepEn;
    logic [CNT_W-1:0] maxReg;
    logic [CNT_W-1:0] cntInc;
    logic [SYM_W-1:0] symNext;
    logic             symNextSpecial;

    assign cntInc = symCount + {{(CNT_W-1){1'b0}}, 1'b1};
    assign symNextSpecial = (symNext == SPECIAL_CODE);

    sym_lfsr #(
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .Clk100M (Clk100M),
        .Rst_n   (Rst_n),
        .stepEn  (stepEn),
        .symNext (symNext)
    );

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Priority in RUN: stop, then restart, then a tick.
    always_comb begin
        stateNext = state;
        loadRun   = 1'b0;
        stepEn    = 1'b0;
        unique case (state)
            IDLE: begin
                if (startGen && !stopGen) begin
                    loadRun   = 1'b1;
                    stateNext = (symGenMax == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (stopGen) begin
                    stateNext = DONE;
                end else if (startGen) begin
                    loadRun = 1'b1;
                    if (symGenMax == '0) begin
                        stateNext = DONE;
                    end
                end else if (Clk1Hz) begin
                    stepEn = 1'b1;
                    if (cntInc == maxReg) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            maxReg       <= '0;
            symValid     <= 1'b0;
            symCode      <= '0;
            isSpecial    <= 1'b0;
            symCount     <= '0;
            specialCount <= '0;
            genDone      <= 1'b0;
        end else begin
            symValid <= stepEn;
            // DONE lasts one cycle, so this yields a single pulse.
            genDone  <= (state == DONE);
            if (loadRun) begin
                maxReg       <= symGenMax;
                symCount     <= '0;
                specialCount <= '0;
            end
            if (stepEn) begin
                symCode   <= symNext;
                isSpecial <= symNextSpecial;
                symCount  <= cntInc;
                if (symNextSpecial && (specialCount != 8'hFF)) begin
                    specialCount <= specialCount + 8'd1;
                end
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_sym_generator.sv
// Self-checking bench for sym_generator.
// Directed plan scenarios plus randomized traffic against a reference model.
module tb_sym_generator;

    logic        Clk100M = 1'b0;
    logic        Rst_n   = 1'b0;
    logic        Clk1Hz  = 1'b0;
    logic        startGen = 1'b0;
    logic        stopGen  = 1'b0;
    logic [31:0] symGenMax = '0;

    logic        symValid, isSpecial, busy, genDone;
    logic [3:0]  symCode;
    logic [31:0] symCount;
    logic [7:0]  specialCount;

    logic        symValid8, isSpecial8, busy8, genDone8;
    logic [3:0]  symCode8;
    logic [31:0] symCount8;
    logic [7:0]  specialCount8;

    int testCnt = 0;
    int errCnt  = 0;

    always #5 Clk100M = ~Clk100M;

    sym_generator dut (
        .Clk100M      (Clk100M),
        .Rst_n        (Rst_n),
        .Clk1Hz       (Clk1Hz),
        .startGen     (startGen),
        .stopGen      (stopGen),
        .symGenMax    (symGenMax),
        .symValid     (symValid),
        .symCode      (symCode),
        .isSpecial    (isSpecial),
        .symCount     (symCount),
        .specialCount (specialCount),
        .busy         (busy),
        .genDone      (genDone)
    );

    sym_generator #(.SPECIAL_CODE(4'h8)) dut8 (
        .Clk100M      (Clk100M),
        .Rst_n        (Rst_n),
        .Clk1Hz       (Clk1Hz),
        .startGen     (startGen),
        .stopGen      (stopGen),
        .symGenMax    (symGenMax),
        .symValid     (symValid8),
        .symCode      (symCode8),
        .isSpecial    (isSpecial8),
        .symCount     (symCount8),
        .specialCount (specialCount8),
        .busy         (busy8),
        .genDone      (genDone8)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: run phase 0=idle 1=running 2=finishing.
    int          mPhase;
    logic [15:0] mLfsr;
    logic [31:0] mMax, mCnt;
    int          mSpec, mSpec8;
    logic [3:0]  mCode;

    // Bookkeeping for directed scenarios.
    int         cyc;
    logic [3:0] emitQ[$];
    logic       spec8Q[$];
    int         doneCnt, doneCyc, lastValid;

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic modelReset();
        mPhase = 0;
        mLfsr  = 16'hACE1;
        mMax   = 0;
        mCnt   = 0;
        mSpec  = 0;
        mSpec8 = 0;
        mCode  = 0;
    endtask

    task automatic clearLog();
        emitQ.delete();
        spec8Q.delete();
        doneCnt   = 0;
        doneCyc   = -100;
        lastValid = -100;
    endtask

    task automatic cycle(input bit st, input bit sp, input bit tk,
                         input logic [31:0] mx);
        bit expValid, expDone;
        @(negedge Clk100M);
        startGen  = st;
        stopGen   = sp;
        Clk1Hz    = tk;
        symGenMax = mx;
        expValid  = 0;
        expDone   = (mPhase == 2);
        if (mPhase == 2) begin
            mPhase = 0;
        end else if (mPhase == 0) begin
            if (st && !sp) begin
                mMax = mx; mCnt = 0; mSpec = 0; mSpec8 = 0;
                mPhase = (mx == 0) ? 2 : 1;
            end
        end else if (sp) begin
            mPhase = 2;
        end else if (st) begin
            mMax = mx; mCnt = 0; mSpec = 0; mSpec8 = 0;
            mPhase = (mx == 0) ? 2 : 1;
        end else if (tk) begin
            mLfsr = lfsrStep(mLfsr);
            mCode = mLfsr[3:0];
            expValid = 1;
            mCnt++;
            if (mCode == 4'hF && mSpec < 255) mSpec++;
            if (mCode == 4'h8 && mSpec8 < 255) mSpec8++;
            if (mCnt == mMax) mPhase = 2;
        end
        @(posedge Clk100M);
        #1;
        cyc++;
        chk("symValid", {31'd0, symValid}, {31'd0, expValid});
        chk("genDone", {31'd0, genDone}, {31'd0, expDone});
        chk("busy", {31'd0, busy}, {31'd0, mPhase == 1});
        chk("symCode", {28'd0, symCode}, {28'd0, mCode});
        chk("isSpecial", {31'd0, isSpecial}, {31'd0, mCode == 4'hF});
        chk("symCount", symCount, mCnt);
        chk("specialCount", {24'd0, specialCount}, mSpec);
        chk("specialCount8", {24'd0, specialCount8}, mSpec8);
        if (symValid) begin
            emitQ.push_back(symCode);
            spec8Q.push_back(isSpecial8);
            lastValid = cyc;
        end
        if (genDone) begin
            doneCnt++;
            doneCyc = cyc;
        end
        startGen = 0;
        stopGen  = 0;
        Clk1Hz   = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        int stopCyc;
        logic [3:0] spBits;
        cyc = 0;
        modelReset();
        clearLog();
        #23;
        chk("rst_symValid", {31'd0, symValid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_genDone", {31'd0, genDone}, 0);
        chk("rst_symCount", symCount, 0);
        @(negedge Clk100M);
        Rst_n = 1;
        idle(3);

        // Max 4 with a tick every 100 cycles.
        clearLog();
        cycle(1, 0, 0, 4);
        for (int k = 0; k < 6; k++) begin
            idle(99);
            cycle(0, 0, 1, 0);
        end
        chk("t1_nsym", emitQ.size(), 4);
        if (emitQ.size() == 4) begin
            chk("t1_code0", {28'd0, emitQ[0]}, 32'h0);
            chk("t1_code1", {28'd0, emitQ[1]}, 32'h8);
            chk("t1_code2", {28'd0, emitQ[2]}, 32'hC);
            chk("t1_code3", {28'd0, emitQ[3]}, 32'hE);
            spBits = {spec8Q[3], spec8Q[2], spec8Q[1], spec8Q[0]};
            chk("t1_spec8bits", {28'd0, spBits}, 32'b0010);
        end
        chk("t1_doneCnt", doneCnt, 1);
        chk("t1_doneLat", doneCyc, lastValid + 1);
        chk("t1_symCount", symCount, 4);
        chk("t1_special", {24'd0, specialCount}, 0);
        chk("t1_special8", {24'd0, specialCount8}, 1);

        // Max 3, stop after the 2nd symbol.
        clearLog();
        cycle(1, 0, 0, 3);
        idle(5); cycle(0, 0, 1, 0);
        idle(5); cycle(0, 0, 1, 0);
        idle(3);
        cycle(0, 1, 0, 0);
        stopCyc = cyc;
        for (int k = 0; k < 3; k++) begin
            idle(4);
            cycle(0, 0, 1, 0);
        end
        chk("t2_nsym", emitQ.size(), 2);
        chk("t2_doneLat", doneCyc, stopCyc + 1);
        chk("t2_doneCnt", doneCnt, 1);
        chk("t2_symCount", symCount, 2);

        // Stop and tick together.
        clearLog();
        cycle(1, 0, 0, 5);
        cycle(0, 0, 1, 0);
        idle(2);
        cycle(0, 1, 1, 0);
        stopCyc = cyc;
        idle(3);
        chk("t3_nsym", emitQ.size(), 1);
        chk("t3_symCount", symCount, 1);
        chk("t3_doneLat", doneCyc, stopCyc + 1);

        // Zero-length run.
        clearLog();
        cycle(1, 0, 0, 0);
        stopCyc = cyc;
        cycle(0, 0, 1, 0);
        idle(3);
        chk("t4_nsym", emitQ.size(), 0);
        chk("t4_doneLat", doneCyc, stopCyc + 1);
        chk("t4_symCount", symCount, 0);

        // Reset mid-run after 2 symbols.
        clearLog();
        cycle(1, 0, 0, 6);
        cycle(0, 0, 1, 0); idle(2);
        cycle(0, 0, 1, 0); idle(2);
        #2;
        Rst_n = 0;
        #1;
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_symCount", symCount, 0);
        chk("t5_symCode", {28'd0, symCode}, 0);
        chk("t5_genDone", {31'd0, genDone}, 0);
        chk("t5_symValid", {31'd0, symValid}, 0);
        modelReset();
        repeat (3) @(posedge Clk100M);
        #1;
        chk("t5_noDone", {31'd0, genDone}, 0);
        @(negedge Clk100M);
        Rst_n = 1;
        clearLog();
        cycle(1, 0, 0, 2);
        cycle(0, 0, 1, 0);
        chk("t5_first", emitQ.size() > 0 ? {28'd0, emitQ[0]} : 32'hFFFF, 0);
        idle(3);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, errCnt);
        $finish;
    end

endmodule
